if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised IF/ID boundary for the pipelined CPU core: a DEPTH-entry instruction queue plus a registered ID-side output stage. It decouples fetch from decode so IF keeps delivering instructions while ID is stalled, and it flushes on branch misprediction. It adds valid/ready handshaking, a branch-prediction sideband bit and an occupancy count. When empty it keeps the single-register behaviour: 1-cycle IF→ID latency.

## Interface
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, occupancy width (derived, not overridden)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; 0 freezes all state
- if_valid  in  1  IF presents an instruction
- if_pc  in  ADDR_W  fetched PC
- if_inst  in  INST_W  fetched instruction
- if_pred_taken  in  1  IF predicted taken
- if_ready  out  1  queue accepts an instruction this cycle
- stall  in  1  ID stalled; output stage must hold
- jump_mistake  in  1  misprediction flush
- id_valid  out  1  output stage holds a real instruction
- id_pc  out  ADDR_W  PC to ID; 0 when bubble
- id_inst  out  INST_W  instruction to ID; 0 when bubble
- id_pred_taken  out  1  prediction bit to ID; 0 when bubble
- occupancy  out  CNT_W  entries in queue, excluding output stage

## Operation
- State: mem[DEPTH] of {pc, inst, pred}; rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap); count (CNT_W); output register {id_valid, id_pc, id_inst, id_pred_taken}.
- if_ready = (count != DEPTH) & !jump_mistake; depends only on registered state and jump_mistake, with no path from if_valid.
- push = if_valid & if_ready; advance = !stall.
- Per-cycle priority: rst > !rdy > jump_mistake > normal.
- rst: count, pointers = 0; all outputs = 0.
- !rdy: every register holds; inputs ignored (no push, no pop).
- jump_mistake: count, rd_ptr, wr_ptr = 0; IF input discarded.
  - If stall = 0, the output register clears to bubble (all zero).
  - If stall = 1, the output register holds (stall outranks flush at the output stage).
- Normal, advance = 1:
  - count > 0: output ← {1, mem[rd_ptr]}; rd_ptr++. A concurrent push writes mem[wr_ptr]; wr_ptr++.
  - count = 0 and push: bypass, output ← {1, if_pc, if_inst, if_pred_taken}; queue untouched.
  - count = 0, no push: output ← bubble (all zero).
- Normal, advance = 0: output holds. A push writes mem[wr_ptr]; wr_ptr++.
- count_next = count + (push & !bypass) − pop, where pop = advance & (count > 0). It never exceeds DEPTH and never underflows.
- Order: FIFO. Instructions reach ID in push order, with none lost or duplicated.
- occupancy = count.

## Timing
- Latency, IF→ID: 1 cycle when the queue is empty and ID is advancing. Otherwise 1 + entries ahead + stall cycles.
- Throughput: 1 instruction/cycle sustained with no stalls. The queue stays empty in steady state.
- Full: if_ready drops in the cycle after count reaches DEPTH. It reasserts in the cycle after the first pop.
- Pop and push when full: impossible, because if_ready = 0.
- Pop and push at count = k > 0: count stays k.
- jump_mistake asserted for one cycle: next cycle count = 0 and if_ready = 1. The first post-flush push bypasses to ID one cycle later, provided stall = 0.
- Reset during a full queue with stall asserted: all state is cleared on that edge; stall is irrelevant.
- rdy low for N cycles: state is bit-identical before and after; held outputs are stable.

## Test plan
- Reset, then push PCs 0x0, 0x4, 0x8 on consecutive cycles with stall = 0 → id_pc = 0x0, 0x4, 0x8 one cycle after each push; occupancy stays 0; id_valid = 1 throughout.
- Stall = 1 while pushing PCs 0x100–0x10C (DEPTH = 4), plus 0x110 → if_ready = 0 once occupancy = 4. 0x110 is held by IF. Releasing stall yields 0x100, 0x104, 0x108, 0x10C, 0x110 in order.
- Queue holds 3 entries, stall = 0, jump_mistake pulse with if_valid = 1, if_pc = 0x200 → next cycle: id_valid = 0, id_pc = 0, id_inst = 0, occupancy = 0; 0x200 is not delivered.
- Flush with stall = 1 and id_pc = 0x40 → id_pc stays 0x40; occupancy = 0.
- rdy = 0 for 5 cycles mid-stream (occupancy = 2, if_valid = 1) → no state change. After rdy returns, the stream resumes in order with no duplicates.
- Wrap-around: 10 push/pop cycles alternating stall at DEPTH = 4 → pointers wrap. The output sequence matches the input order; id_pred_taken tracks each entry.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID pipeline boundary: a DEPTH-entry instruction FIFO in front of a
// registered ID-side output stage. Fetch keeps delivering while decode is
// stalled, and the whole boundary flushes on a branch misprediction.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rdy               global ready; low freezes every register
//   if_valid/if_pc/if_inst/if_pred_taken   fetch-side instruction
//   if_ready          queue can accept an instruction this cycle
//   stall             decode stalled; output stage holds
//   jump_mistake      misprediction flush
//   id_valid/id_pc/id_inst/id_pred_taken   decode-side instruction (zero on bubble)
//   occupancy         entries waiting in the FIFO (output stage not counted)
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_pred_taken,
  output logic              if_ready,
  input  logic              stall,
  input  logic              jump_mistake,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_pred_taken,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              pred;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  entry_t           out_q, out_d;

  logic   mem_we;
  entry_t if_entry;
  logic   push, advance, pop, bypass, not_empty;

  assign if_entry  = '{pc: if_pc, inst: if_inst, pred: if_pred_taken};
  assign not_empty = (count_q != '0);

  // Registered state plus the flush input only; no path from if_valid.
  assign if_ready = (count_q != CNT_W'(DEPTH)) && !jump_mistake;

  assign push    = if_valid && if_ready;
  assign advance = !stall;
  assign pop     = advance && not_empty;
  // With an empty queue an advancing output stage takes IF directly.
  assign bypass  = advance && !not_empty && push;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    mem_we      = 1'b0;

    if (rdy) begin
      if (jump_mistake) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
        // A stalled decode stage keeps its instruction even across a flush.
        if (!stall) begin
          out_valid_d = 1'b0;
          out_d       = '0;
        end
      end else begin
        if (advance) begin
          out_valid_d = 1'b1;
          if (not_empty) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end else if (push) begin
            out_d = if_entry;
          end else begin
            out_valid_d = 1'b0;
            out_d       = '0;
          end
        end
        if (push && !bypass) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push && !bypass) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // Storage needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_ptr_q] <= if_entry;
    end
  end

  assign id_valid      = out_valid_q;
  assign id_pc         = out_q.pc;
  assign id_inst       = out_q.inst;
  assign id_pred_taken = out_q.pred;
  assign occupancy     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_pred_taken;
  logic             if_ready;
  logic             stall;
  logic             jump_mistake;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic             id_pred_taken;
  logic [CNT_W-1:0] occupancy;

  if_id_queue #(
    .ADDR_W(32),
    .INST_W(32),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_pred_taken(if_pred_taken),
    .if_ready     (if_ready),
    .stall        (stall),
    .jump_mistake (jump_mistake),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_pred_taken(id_pred_taken),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  // Reference model: a plain queue plus the instruction visible to decode.
  ent_t mq[$];
  logic m_valid;
  ent_t m_out;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   accept;
    e = '{pc: if_pc, inst: if_inst, pred: if_pred_taken};
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      if (jump_mistake) begin
        mq.delete();
        if (!stall) begin
          m_valid = 1'b0;
          m_out   = '0;
        end
      end else begin
        accept = if_valid && (mq.size() < DEPTH);
        if (!stall) begin
          if (mq.size() > 0) begin
            m_valid = 1'b1;
            m_out   = mq.pop_front();
            if (accept) mq.push_back(e);
          end else if (accept) begin
            m_valid = 1'b1;
            m_out   = e;
          end else begin
            m_valid = 1'b0;
            m_out   = '0;
          end
        end else if (accept) begin
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("id_valid", 64'(id_valid), 64'(m_valid));
    chk("id_pc", 64'(id_pc), 64'(m_out.pc));
    chk("id_inst", 64'(id_inst), 64'(m_out.inst));
    chk("id_pred_taken", 64'(id_pred_taken), 64'(m_out.pred));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
  endtask

  // Inputs are already applied; check if_ready, clock once, check outputs.
  task automatic tick();
    bit exp_ready;
    #1;
    exp_ready = (mq.size() != DEPTH) && !jump_mistake;
    chk("if_ready", 64'(if_ready), 64'(exp_ready));
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic pr,
                     input logic st, input logic jm);
    if_valid      = v;
    if_pc         = pc;
    if_inst       = pc ^ 32'hA5A5_0F0F;
    if_pred_taken = pr;
    stall         = st;
    jump_mistake  = jm;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    if_valid = 1'b0;
    if_pc = '0;
    if_inst = '0;
    if_pred_taken = 1'b0;
    stall = 1'b0;
    jump_mistake = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();

    // Back-to-back bypass with an empty queue.
    drv(1, 32'h0, 0, 0, 0);
    drv(1, 32'h4, 1, 0, 0);
    drv(1, 32'h8, 0, 0, 0);
    drv(0, 32'h0, 0, 0, 0);

    // Fill while stalled; 0x110 is refused until the first pop frees a slot.
    drv(1, 32'h100, 0, 1, 0);
    drv(1, 32'h104, 1, 1, 0);
    drv(1, 32'h108, 0, 1, 0);
    drv(1, 32'h10C, 1, 1, 0);
    drv(1, 32'h110, 1, 1, 0);
    drv(1, 32'h110, 1, 1, 0);
    drv(1, 32'h110, 1, 0, 0);
    drv(1, 32'h110, 1, 0, 0);
    for (int i = 0; i < 5; i++) drv(0, 32'h0, 0, 0, 0);

    // Flush with three queued entries and decode advancing.
    drv(1, 32'h300, 0, 1, 0);
    drv(1, 32'h304, 0, 1, 0);
    drv(1, 32'h308, 0, 1, 0);
    drv(1, 32'h200, 1, 0, 1);
    drv(0, 32'h0, 0, 0, 0);
    drv(1, 32'h204, 1, 0, 0);
    drv(0, 32'h0, 0, 0, 0);

    // Flush while stalled: decode keeps 0x40.
    drv(1, 32'h40, 0, 0, 0);
    drv(1, 32'h44, 0, 1, 0);
    drv(1, 32'h48, 0, 1, 0);
    drv(1, 32'h4C, 0, 1, 1);
    drv(0, 32'h0, 0, 1, 0);
    drv(0, 32'h0, 0, 0, 0);

    // Freeze with two entries queued and IF still offering.
    drv(1, 32'h500, 1, 1, 0);
    drv(1, 32'h504, 0, 1, 0);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) drv(1, 32'h600 + 32'(i * 4), 1, 0, 0);
    rdy = 1'b1;
    drv(1, 32'h508, 1, 0, 0);
    for (int i = 0; i < 4; i++) drv(0, 32'h0, 0, 0, 0);

    // Pointer wrap-around with alternating stall.
    for (int i = 0; i < 10; i++) drv(1, 32'h700 + 32'(i * 4), 1'(i), 1'(i % 2), 0);
    for (int i = 0; i < 6; i++) drv(0, 32'h0, 0, 0, 0);

    // Reset with a full queue and decode stalled.
    for (int i = 0; i < 5; i++) drv(1, 32'h800 + 32'(i * 4), 0, 1, 0);
    rst = 1'b1;
    drv(1, 32'h900, 1, 1, 0);
    rst = 1'b0;
    drv(0, 32'h0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      drv(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom),
          1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
    end
    rst = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) drv(0, 32'h0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
